// File: rtl/axi4_pkg.sv
// Shared AXI4 response codes and FSM state types for the memory slave.
package axi4_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi4_be_ram.sv
// Byte-enabled word memory with a registered, read-before-write read port.
// Reset reloads every word with its own index.
module axi4_be_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
  input  logic [DATA_W/8-1:0]                      wstrb,
  input  logic [DATA_W-1:0]                        wdata,
  input  logic                                     re,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
  output logic [DATA_W-1:0]                        rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read samples the array before this edge's write lands, so a same-word
  // collision returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      rdata <= '0;
    end else begin
      if (re) rdata <= mem[raddr];
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave: independent write and read engines in front
// of a byte-enabled RAM, with range-checked SLVERR responses and ID echo.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   dw_data,
  input  logic [DATA_W/8-1:0] dw_strb,
  input  logic                dw_last,
  input  logic                dw_valid,
  output logic                dw_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [7:0]          ar_len,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [ID_W-1:0]     dr_id,
  output logic [DATA_W-1:0]   dr_data,
  output logic [1:0]          dr_resp,
  output logic                dr_last,
  output logic                dr_valid,
  input  logic                dr_ready
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One spare bit so a burst running past the top of the address space
  // still compares as out of range instead of wrapping to a low word.
  localparam int IW  = ADDR_W - OFF + 1;

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IW'(a >> OFF);
  endfunction

  function automatic logic out_of_range(input logic [IW-1:0] idx);
    return idx >= IW'(DEPTH);
  endfunction

  wr_state_t         wr_state, wr_state_nxt;
  logic [ID_W-1:0]   wr_id;
  logic [IW-1:0]     wr_idx;
  logic [7:0]        wr_len, wr_cnt;
  logic              wr_err;
  logic              wr_end;

  rd_state_t         rd_state, rd_state_nxt;
  logic [ID_W-1:0]   rd_id;
  logic [IW-1:0]     rd_idx, rd_next_idx;
  logic [7:0]        rd_len, rd_cnt;
  logic              rd_end;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_q;

  assign wr_end = (wr_cnt == wr_len);
  assign rd_end = (rd_cnt == rd_len);

  // Write engine
  always_comb begin
    wr_state_nxt = wr_state;
    aw_ready     = 1'b0;
    dw_ready     = 1'b0;
    b_valid      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (aw_valid) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        dw_ready = 1'b1;
        if (dw_valid && wr_end) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_id    <= '0;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (aw_ready && aw_valid) begin
        wr_id  <= aw_id;
        wr_idx <= word_idx(aw_addr);
        wr_len <= aw_len;
        wr_cnt <= '0;
        wr_err <= 1'b0;
      end
      if (dw_ready && dw_valid) begin
        // The beat count alone terminates the burst; a misplaced dw_last
        // is only reported.
        if (out_of_range(wr_idx) || (dw_last != wr_end)) wr_err <= 1'b1;
        if (!wr_end) begin
          wr_cnt <= wr_cnt + 8'd1;
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end
  end

  assign ram_we = dw_ready && dw_valid && !out_of_range(wr_idx);
  assign b_id   = wr_id;
  assign b_resp = (b_valid && wr_err) ? SLVERR : OKAY;

  // Read engine
  always_comb begin
    rd_state_nxt = rd_state;
    ar_ready     = 1'b0;
    dr_valid     = 1'b0;
    case (rd_state)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        dr_valid = 1'b1;
        if (dr_ready && rd_end) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  assign dr_last = dr_valid && rd_end;

  // The RAM is fetched only when a new beat is accepted, so the registered
  // word (and hence the payload) holds while the master stalls.
  assign rd_next_idx = (rd_state == R_IDLE) ? word_idx(ar_addr) : (rd_idx + IW'(1));
  assign ram_re      = (ar_ready && ar_valid) || (dr_valid && dr_ready && !rd_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_id    <= '0;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ram_re) rd_idx <= rd_next_idx;
      if (ar_ready && ar_valid) begin
        rd_id  <= ar_id;
        rd_len <= ar_len;
        rd_cnt <= '0;
      end else if (dr_valid && dr_ready && !rd_end) begin
        rd_cnt <= rd_cnt + 8'd1;
      end
    end
  end

  assign dr_id   = rd_id;
  assign dr_data = (dr_valid && !out_of_range(rd_idx)) ? ram_q : '0;
  assign dr_resp = (dr_valid && out_of_range(rd_idx)) ? SLVERR : OKAY;

  axi4_be_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (ram_we),
    .waddr (wr_idx[AW-1:0]),
    .wstrb (dw_strb),
    .wdata (dw_data),
    .re    (ram_re),
    .raddr (rd_next_idx[AW-1:0]),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: a word-array memory model predicts every
// read beat and write response, checked by one monitor on each falling edge.
module tb_axi4_mem_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic              aw_valid, aw_ready;
  logic [DATA_W-1:0] dw_data;
  logic [3:0]        dw_strb;
  logic              dw_last, dw_valid, dw_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic              b_valid, b_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic              ar_valid, ar_ready;
  logic [ID_W-1:0]   dr_id;
  logic [DATA_W-1:0] dr_data;
  logic [1:0]        dr_resp;
  logic              dr_last, dr_valid, dr_ready;

  always #5 clk = ~clk;

  axi4_mem_slave #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .ID_W (ID_W)
  ) dut (
    .clk (clk), .rst (rst),
    .aw_id (aw_id), .aw_addr (aw_addr), .aw_len (aw_len),
    .aw_valid (aw_valid), .aw_ready (aw_ready),
    .dw_data (dw_data), .dw_strb (dw_strb), .dw_last (dw_last),
    .dw_valid (dw_valid), .dw_ready (dw_ready),
    .b_id (b_id), .b_resp (b_resp), .b_valid (b_valid), .b_ready (b_ready),
    .ar_id (ar_id), .ar_addr (ar_addr), .ar_len (ar_len),
    .ar_valid (ar_valid), .ar_ready (ar_ready),
    .dr_id (dr_id), .dr_data (dr_data), .dr_resp (dr_resp),
    .dr_last (dr_last), .dr_valid (dr_valid), .dr_ready (dr_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] mm [DEPTH];
  bit          mon_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) mm[i] = i;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_aw_ready"}, aw_ready, 1);
    chk({tag, "_ar_ready"}, ar_ready, 1);
    chk({tag, "_dw_ready"}, dw_ready, 0);
    chk({tag, "_b_valid"},  b_valid,  0);
    chk({tag, "_dr_valid"}, dr_valid, 0);
    chk({tag, "_dr_last"},  dr_last,  0);
    chk({tag, "_b_resp"},   b_resp,   0);
    chk({tag, "_dr_resp"},  dr_resp,  0);
    chk({tag, "_dr_data"},  dr_data,  0);
    chk({tag, "_b_id"},     b_id,     0);
    chk({tag, "_dr_id"},    dr_id,    0);
  endtask

  // Single compare process: any presented beat/response must match the head
  // of the model's queue; it is consumed only when the bench shows ready.
  always @(negedge clk) begin
    if (mon_on && rst) begin
      if (dr_valid) begin
        if (rq.size() == 0) chk("dr_valid_unexpected", dr_valid, 0);
        else begin
          chk("dr_data", dr_data, rq[0].data);
          chk("dr_resp", dr_resp, rq[0].resp);
          chk("dr_last", dr_last, rq[0].last);
          chk("dr_id",   dr_id,   rq[0].id);
          if (dr_ready) void'(rq.pop_front());
        end
      end
      if (b_valid) begin
        if (bq.size() == 0) chk("b_valid_unexpected", b_valid, 0);
        else begin
          chk("b_id",   b_id,   bq[0].id);
          chk("b_resp", b_resp, bq[0].resp);
          if (b_ready) void'(bq.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [31:0] data0, input logic [3:0] strb,
                          input bit bad_last, input logic [1:0] lit_bresp);
    int    idx0;
    bit    err;
    bexp_t be;
    idx0 = int'(addr >> 2);
    err  = 1'b0;
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = 8'(len);
    @(negedge clk);
    chk("aw_ready_idle", aw_ready, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      logic [31:0] d;
      logic        lst;
      int          i;
      d   = data0 + 32'(k);
      i   = idx0 + k;
      lst = bad_last ? (k == 0) : (k == len);
      if (lst != (k == len)) err = 1'b1;
      if (i < DEPTH) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mm[i][8*b +: 8] = d[8*b +: 8];
      end else begin
        err = 1'b1;
      end
      dw_valid = 1'b1; dw_data = d; dw_strb = strb; dw_last = lst;
      @(negedge clk);
      chk("dw_ready_beat", dw_ready, 1);
      @(posedge clk); #1;
    end
    dw_valid = 1'b0; dw_last = 1'b0;
    be.id   = id;
    be.resp = err ? 2'b10 : 2'b00;
    bq.push_back(be);
    b_ready = 1'b1;
    @(negedge clk);
    chk("b_valid_latency", b_valid, 1);
    chk("b_resp_literal", b_resp, lit_bresp);
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input int len);
    for (int k = 0; k <= len; k++) begin
      rbeat_t e;
      int     i;
      i      = int'(addr >> 2) + k;
      e.data = (i < DEPTH) ? mm[i] : 32'h0;
      e.resp = (i < DEPTH) ? 2'b00 : 2'b10;
      e.last = (k == len);
      e.id   = id;
      rq.push_back(e);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input bit toggle, input logic [31:0] lit_first);
    int cyc;
    push_read(id, addr, len);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
    @(negedge clk);
    chk("ar_ready_idle", ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    dr_ready = toggle ? 1'b0 : 1'b1;
    @(negedge clk);
    chk("dr_valid_latency", dr_valid, 1);
    chk("dr_data_first_literal", dr_data, lit_first);
    cyc = 0;
    while (rq.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      if (toggle) dr_ready = ~dr_ready;
      cyc++;
    end
    if (rq.size() != 0) begin
      chk("rd_done_timeout", rq.size(), 0);
      rq.delete();
    end
    @(posedge clk); #1;
    dr_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
    dw_valid = 0; dw_data = 0; dw_strb = 0; dw_last = 0;
    b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
    dr_ready = 0;
    model_init();
    #3;
    reset_checks("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_on = 1'b1;

    // single write then read back
    do_write(4'd1, 32'h10, 0, 32'hDEADBEEF, 4'hF, 1'b0, 2'b00);
    do_read(4'd2, 32'h10, 0, 1'b0, 32'hDEADBEEF);

    // partial strobe onto preload value 8
    do_write(4'd2, 32'h20, 0, 32'hAABBCCDD, 4'b0101, 1'b0, 2'b00);
    chk("model_pin_strb", mm[8], 32'h00BB00DD);
    do_read(4'd1, 32'h20, 0, 1'b0, 32'h00BB00DD);

    // 4-beat read under toggling back-pressure
    do_read(4'd9, 32'h0, 3, 1'b1, 32'h0);

    // burst straddling the end of memory, then a fully out-of-range read
    do_write(4'd4, 32'h3F8, 3, 32'h11110000, 4'hF, 1'b0, 2'b10);
    chk("model_pin_oor", mm[255], 32'h11110001);
    do_read(4'd4, 32'h3F8, 3, 1'b0, 32'h11110000);
    do_read(4'd6, 32'h4B0, 0, 1'b0, 32'h0);

    // dw_last misplaced on both beats
    do_write(4'd7, 32'h60, 1, 32'h5A5A0000, 4'hF, 1'b1, 2'b10);
    do_read(4'd7, 32'h60, 1, 1'b0, 32'h5A5A0000);

    // write data beat and AR handshake hit word 16 on the same edge
    fork
      do_write(4'd3, 32'h40, 0, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00);
      begin
        @(posedge clk);
        do_read(4'd5, 32'h40, 0, 1'b0, 32'd16);
      end
    join
    do_read(4'd5, 32'h40, 0, 1'b0, 32'hCAFEF00D);

    // reset while beat 2 of an 8-beat read is on the bus
    push_read(4'd6, 32'h0, 7);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_id = 4'd6; ar_addr = 32'h0; ar_len = 8'd7;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    dr_ready = 1'b1;
    cyc = 0;
    while (rq.size() > 6 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    chk("pre_reset_beats_taken", rq.size(), 6);
    #2 rst = 1'b0;
    #1;
    reset_checks("midreset");
    rq.delete();
    bq.delete();
    model_init();
    dr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    do_read(4'd8, 32'h0, 8, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    chk("rd_queue_drained", rq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
